lsu: RTL and testbench

Load/store stage directly downstream of the execute stage: takes the ALU result as an effective address, issues one request on a valid/ready data-memory port and formats the load data. Its result goes to the write-back stage. Non-memory instructions pass through unchanged. A response timeout and optional misalignment trapping make the stage self-recovering.

---
 rtl/lsu_pkg.sv | 32 +++
 rtl/lsu_fmt.sv | 68 ++++++
 rtl/lsu.sv | 165 ++++++++++++++++
 tb/tb_lsu.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: data widths, access type codes, FSM state codes and type helpers.
package lsu_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned ARGS_WIDTH = 4;

  localparam logic [ARGS_WIDTH-1:0] LSU_NONE = 4'd0;
  localparam logic [ARGS_WIDTH-1:0] LSU_LB   = 4'd1;
  localparam logic [ARGS_WIDTH-1:0] LSU_LH   = 4'd2;
  localparam logic [ARGS_WIDTH-1:0] LSU_LW   = 4'd3;
  localparam logic [ARGS_WIDTH-1:0] LSU_LBU  = 4'd4;
  localparam logic [ARGS_WIDTH-1:0] LSU_LHU  = 4'd5;
  localparam logic [ARGS_WIDTH-1:0] LSU_SB   = 4'd6;
  localparam logic [ARGS_WIDTH-1:0] LSU_SH   = 4'd7;
  localparam logic [ARGS_WIDTH-1:0] LSU_SW   = 4'd8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Codes above LSU_SW are unknown and behave like LSU_NONE.
  function automatic logic is_mem_op(input logic [ARGS_WIDTH-1:0] t);
    return (t != LSU_NONE) && (t <= LSU_SW);
  endfunction

  function automatic logic is_store(input logic [ARGS_WIDTH-1:0] t);
    return (t >= LSU_SB) && (t <= LSU_SW);
  endfunction

endpackage

// File: rtl/lsu_fmt.sv
// Combinational load extraction/extension and store lane/mask generation.
// Misalignment detection is present only when LSU_MISALIGN_CHK_EN is defined.
module lsu_fmt
  import lsu_pkg::*;
(
  input  logic [ARGS_WIDTH-1:0] lsu_type,
  input  logic [1:0]            off,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] load_word,
  output logic [DATA_WIDTH-1:0] wdata_c,
  output logic [3:0]            wmask_c,
  output logic [DATA_WIDTH-1:0] load_c
`ifdef LSU_MISALIGN_CHK_EN
  ,
  output logic                  misalign_c
`endif
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfwords select on addr[1] only, so addr[0] is ignored without the check.
  always_comb begin
    byte_sel = load_word[{off, 3'b000} +: 8];
    half_sel = load_word[{off[1], 4'b0000} +: 16];
    load_c   = '0;
    case (lsu_type)
      LSU_LB:  load_c = {{24{byte_sel[7]}}, byte_sel};
      LSU_LBU: load_c = {24'd0, byte_sel};
      LSU_LH:  load_c = {{16{half_sel[15]}}, half_sel};
      LSU_LHU: load_c = {16'd0, half_sel};
      LSU_LW:  load_c = load_word;
      default: ;
    endcase
  end

  always_comb begin
    wdata_c = '0;
    wmask_c = '0;
    case (lsu_type)
      LSU_SB: begin
        wdata_c = {4{store_data[7:0]}};
        wmask_c = 4'b0001 << off;
      end
      LSU_SH: begin
        wdata_c = {2{store_data[15:0]}};
        wmask_c = 4'b0011 << {off[1], 1'b0};
      end
      LSU_SW: begin
        wdata_c = store_data;
        wmask_c = 4'b1111;
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_CHK_EN
  always_comb begin
    misalign_c = 1'b0;
    case (lsu_type)
      LSU_LH, LSU_LHU, LSU_SH: misalign_c = off[0];
      LSU_LW, LSU_SW:          misalign_c = |off;
      default: ;
    endcase
  end
`endif

endmodule

// File: rtl/lsu.sv
// Load/store stage: one data-memory access per instruction with response timeout.
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_CHK_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_sys_valid,
  output logic                  o_sys_ready,
  output logic                  o_sys_valid,
  input  logic                  i_sys_ready,
  input  logic [ARGS_WIDTH-1:0] i_idu_ctr_lsu_type,
  input  logic [DATA_WIDTH-1:0] i_exu_res,
  input  logic [DATA_WIDTH-1:0] i_idu_rs2_data,
  input  logic [4:0]            i_idu_rd_id,
  input  logic                  i_idu_rd_wr_en,
  output logic                  o_lsu_mem_req_valid,
  input  logic                  i_lsu_mem_req_ready,
  output logic                  o_lsu_mem_we,
  output logic [ADDR_WIDTH-1:0] o_lsu_mem_addr,
  output logic [DATA_WIDTH-1:0] o_lsu_mem_wdata,
  output logic [3:0]            o_lsu_mem_wmask,
  input  logic                  i_lsu_mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] i_lsu_mem_rdata,
  output logic [DATA_WIDTH-1:0] o_lsu_res,
  output logic [4:0]            o_lsu_rd_id,
  output logic                  o_lsu_rd_wr_en,
  output logic                  o_lsu_err
`ifdef LSU_MISALIGN_CHK_EN
  ,
  output logic                  o_lsu_misalign
`endif
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [ARGS_WIDTH-1:0] cur_type;
  logic [1:0]            cur_off;
  logic [7:0]            cnt;
  logic                  accept;
  logic                  handshake;
  logic                  timeout;
  logic                  mis;
  logic [ARGS_WIDTH-1:0] fmt_type;
  logic [1:0]            fmt_off;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [DATA_WIDTH-1:0] load_c;
  logic [3:0]            wmask_c;

  // Formatter sees upstream fields while idle (store lanes), captured ones afterwards (load data).
  assign fmt_type = (state == S_IDLE) ? i_idu_ctr_lsu_type : cur_type;
  assign fmt_off  = (state == S_IDLE) ? i_exu_res[1:0] : cur_off;

  lsu_fmt u_fmt (
    .lsu_type   (fmt_type),
    .off        (fmt_off),
    .store_data (i_idu_rs2_data),
    .load_word  (i_lsu_mem_rdata),
    .wdata_c    (wdata_c),
    .wmask_c    (wmask_c),
    .load_c     (load_c)
`ifdef LSU_MISALIGN_CHK_EN
    ,
    .misalign_c (mis)
`endif
  );

`ifndef LSU_MISALIGN_CHK_EN
  assign mis = 1'b0;
`endif

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    handshake  = 1'b0;
    timeout    = 1'b0;
    case (state)
      S_IDLE: if (i_sys_valid) begin
        accept     = 1'b1;
        state_next = (is_mem_op(i_idu_ctr_lsu_type) && !mis) ? S_REQ : S_DONE;
      end
      S_REQ: if (i_lsu_mem_req_ready) begin
        handshake  = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_lsu_mem_rsp_valid) begin
          state_next = S_DONE;
        end else if (cnt == TMO_LAST) begin
          timeout    = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: if (i_sys_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they are valid on state entry.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state               <= S_IDLE;
      cur_type            <= '0;
      cur_off             <= '0;
      cnt                 <= '0;
      o_sys_ready         <= 1'b0;
      o_sys_valid         <= 1'b0;
      o_lsu_mem_req_valid <= 1'b0;
      o_lsu_mem_we        <= 1'b0;
      o_lsu_mem_addr      <= '0;
      o_lsu_mem_wdata     <= '0;
      o_lsu_mem_wmask     <= '0;
      o_lsu_res           <= '0;
      o_lsu_rd_id         <= '0;
      o_lsu_rd_wr_en      <= 1'b0;
      o_lsu_err           <= 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
      o_lsu_misalign      <= 1'b0;
`endif
    end else begin
      state               <= state_next;
      o_sys_ready         <= (state_next == S_IDLE);
      o_sys_valid         <= (state_next == S_DONE);
      o_lsu_mem_req_valid <= (state_next == S_REQ);

      if (accept) begin
        cur_type       <= i_idu_ctr_lsu_type;
        cur_off        <= i_exu_res[1:0];
        o_lsu_rd_id    <= i_idu_rd_id;
        o_lsu_rd_wr_en <= i_idu_rd_wr_en & ~mis;
        o_lsu_err      <= mis;
        o_lsu_res      <= is_mem_op(i_idu_ctr_lsu_type) ? '0 : i_exu_res;
`ifdef LSU_MISALIGN_CHK_EN
        o_lsu_misalign <= mis;
`endif
        if (state_next == S_REQ) begin
          o_lsu_mem_addr  <= {i_exu_res[ADDR_WIDTH-1:2], 2'b00};
          o_lsu_mem_we    <= is_store(i_idu_ctr_lsu_type);
          o_lsu_mem_wdata <= wdata_c;
          o_lsu_mem_wmask <= wmask_c;
        end
      end

      if (handshake) cnt <= '0;

      // Stores complete with a zero result: the formatter yields 0 for non-load types.
      if (state == S_WAIT) begin
        if (i_lsu_mem_rsp_valid) begin
          o_lsu_res <= load_c;
        end else if (timeout) begin
          o_lsu_err      <= 1'b1;
          o_lsu_rd_wr_en <= 1'b0;
          o_lsu_res      <= '0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus random transactions against a reference model.
module tb_lsu;
  import lsu_pkg::*;

  localparam int unsigned TMO = 4;

  logic                  i_sys_clk;
  logic                  i_sys_rst;
  logic                  i_sys_valid;
  logic                  o_sys_ready;
  logic                  o_sys_valid;
  logic                  i_sys_ready;
  logic [ARGS_WIDTH-1:0] i_idu_ctr_lsu_type;
  logic [31:0]           i_exu_res;
  logic [31:0]           i_idu_rs2_data;
  logic [4:0]            i_idu_rd_id;
  logic                  i_idu_rd_wr_en;
  logic                  o_lsu_mem_req_valid;
  logic                  i_lsu_mem_req_ready;
  logic                  o_lsu_mem_we;
  logic [31:0]           o_lsu_mem_addr;
  logic [31:0]           o_lsu_mem_wdata;
  logic [3:0]            o_lsu_mem_wmask;
  logic                  i_lsu_mem_rsp_valid;
  logic [31:0]           i_lsu_mem_rdata;
  logic [31:0]           o_lsu_res;
  logic [4:0]            o_lsu_rd_id;
  logic                  o_lsu_rd_wr_en;
  logic                  o_lsu_err;
`ifdef LSU_MISALIGN_CHK_EN
  logic                  o_lsu_misalign;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  initial i_sys_clk = 1'b0;
  always #5 i_sys_clk = ~i_sys_clk;

  lsu #(.MEM_TIMEOUT(TMO)) dut (
    .i_sys_clk           (i_sys_clk),
    .i_sys_rst           (i_sys_rst),
    .i_sys_valid         (i_sys_valid),
    .o_sys_ready         (o_sys_ready),
    .o_sys_valid         (o_sys_valid),
    .i_sys_ready         (i_sys_ready),
    .i_idu_ctr_lsu_type  (i_idu_ctr_lsu_type),
    .i_exu_res           (i_exu_res),
    .i_idu_rs2_data      (i_idu_rs2_data),
    .i_idu_rd_id         (i_idu_rd_id),
    .i_idu_rd_wr_en      (i_idu_rd_wr_en),
    .o_lsu_mem_req_valid (o_lsu_mem_req_valid),
    .i_lsu_mem_req_ready (i_lsu_mem_req_ready),
    .o_lsu_mem_we        (o_lsu_mem_we),
    .o_lsu_mem_addr      (o_lsu_mem_addr),
    .o_lsu_mem_wdata     (o_lsu_mem_wdata),
    .o_lsu_mem_wmask     (o_lsu_mem_wmask),
    .i_lsu_mem_rsp_valid (i_lsu_mem_rsp_valid),
    .i_lsu_mem_rdata     (i_lsu_mem_rdata),
    .o_lsu_res           (o_lsu_res),
    .o_lsu_rd_id         (o_lsu_rd_id),
    .o_lsu_rd_wr_en      (o_lsu_rd_wr_en),
    .o_lsu_err           (o_lsu_err)
`ifdef LSU_MISALIGN_CHK_EN
    ,
    .o_lsu_misalign      (o_lsu_misalign)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain shift/mask arithmetic over the access rules.
  function automatic logic [31:0] exp_load(input logic [3:0] t, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    logic [31:0] b;
    logic [31:0] h;
    b = (rdata >> (8 * addr[1:0])) & 32'hFF;
    h = (rdata >> (addr[1] ? 16 : 0)) & 32'hFFFF;
    case (t)
      4'd1: return b[7] ? (b | 32'hFFFF_FF00) : b;
      4'd4: return b;
      4'd2: return h[15] ? (h | 32'hFFFF_0000) : h;
      4'd5: return h;
      4'd3: return rdata;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [3:0] t, input logic [31:0] rs2);
    case (t)
      4'd6: return (rs2 & 32'hFF) * 32'h0101_0101;
      4'd7: return (rs2 & 32'hFFFF) * 32'h0001_0001;
      4'd8: return rs2;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] exp_wmask(input logic [3:0] t, input logic [31:0] addr);
    case (t)
      4'd6: return 4'b0001 << addr[1:0];
      4'd7: return addr[1] ? 4'b1100 : 4'b0011;
      4'd8: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic bit model_mis(input logic [3:0] t, input logic [31:0] addr);
`ifdef LSU_MISALIGN_CHK_EN
    if ((t == 4'd2 || t == 4'd5 || t == 4'd7) && addr[0]) return 1'b1;
    if ((t == 4'd3 || t == 4'd8) && addr[1:0] != 2'b00) return 1'b1;
`endif
    return (t > 4'd15);
  endfunction

  // One instruction end to end; called and returns at a falling edge with the DUT idle.
  task automatic run_txn(input logic [3:0] t, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic wren, input logic [31:0] rdata,
                         input int req_wait, input int rsp_wait, input int out_wait,
                         input logic hs_glitch);
    bit          mem;
    bit          st;
    bit          mis;
    bit          err;
    bit          done;
    int          c;
    int          exp_c;
    logic [31:0] exp_res;
    mis = model_mis(t, addr);
    mem = (t >= 4'd1) && (t <= 4'd8) && !mis;
    st  = (t >= 4'd6) && (t <= 4'd8);
    check("idle_ready", o_sys_ready, 1);
    i_sys_valid = 1'b1;
    i_idu_ctr_lsu_type = t;
    i_exu_res = addr;
    i_idu_rs2_data = rs2;
    i_idu_rd_id = rd;
    i_idu_rd_wr_en = wren;
    @(posedge i_sys_clk); @(negedge i_sys_clk);
    i_sys_valid = 1'b0;
    i_idu_ctr_lsu_type = 4'($urandom);
    i_exu_res = $urandom;
    i_idu_rs2_data = $urandom;
    i_idu_rd_id = 5'($urandom);
    check("busy_ready", o_sys_ready, 0);
    if (mem) begin
      for (int k = 0; k <= req_wait; k++) begin
        check("req_valid", o_lsu_mem_req_valid, 1);
        check("req_addr", o_lsu_mem_addr, addr & 32'hFFFF_FFFC);
        check("req_we", o_lsu_mem_we, st);
        check("req_wdata", o_lsu_mem_wdata, exp_wdata(t, rs2));
        check("req_wmask", o_lsu_mem_wmask, exp_wmask(t, addr));
        i_lsu_mem_req_ready = (k == req_wait);
        i_lsu_mem_rsp_valid = (k == req_wait) && hs_glitch;
        i_lsu_mem_rdata = $urandom;
        @(posedge i_sys_clk); @(negedge i_sys_clk);
      end
      i_lsu_mem_req_ready = 1'b0;
      i_lsu_mem_rsp_valid = 1'b0;
      check("req_drop", o_lsu_mem_req_valid, 0);
      done = 1'b0;
      c = 0;
      while (!done && c < int'(TMO) + 3) begin
        c++;
        i_lsu_mem_rsp_valid = (c == rsp_wait);
        i_lsu_mem_rdata = (c == rsp_wait) ? rdata : $urandom;
        @(posedge i_sys_clk); @(negedge i_sys_clk);
        i_lsu_mem_rsp_valid = 1'b0;
        done = o_sys_valid;
      end
      err   = (rsp_wait > int'(TMO));
      exp_c = err ? int'(TMO) : rsp_wait;
      check("wait_cycles", c, exp_c);
      exp_res = (err || st) ? 32'h0 : exp_load(t, addr, rdata);
    end else begin
      err = mis;
      exp_res = mis ? 32'h0 : addr;
    end
    for (int k = 0; k <= out_wait; k++) begin
      check("out_valid", o_sys_valid, 1);
      check("out_res", o_lsu_res, exp_res);
      check("out_rd_id", o_lsu_rd_id, rd);
      check("out_rd_wr_en", o_lsu_rd_wr_en, wren && !err);
      check("out_err", o_lsu_err, err);
      check("out_no_req", o_lsu_mem_req_valid, 0);
`ifdef LSU_MISALIGN_CHK_EN
      check("out_misalign", o_lsu_misalign, mis);
`endif
      i_sys_ready = (k == out_wait);
      i_lsu_mem_rsp_valid = 1'($urandom);
      i_lsu_mem_rdata = $urandom;
      @(posedge i_sys_clk); @(negedge i_sys_clk);
      i_lsu_mem_rsp_valid = 1'b0;
    end
    i_sys_ready = 1'b0;
    check("release", {o_sys_valid, o_sys_ready}, 2'b01);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {o_sys_ready, o_sys_valid, o_lsu_mem_req_valid, o_lsu_mem_we,
                o_lsu_err, o_lsu_rd_wr_en, o_lsu_rd_id, o_lsu_mem_wmask}, 0);
    check(tag, o_lsu_mem_addr | o_lsu_mem_wdata | o_lsu_res, 0);
  endtask

  task automatic stale_rsp_idle(input string tag);
    i_lsu_mem_rsp_valid = 1'b1;
    i_lsu_mem_rdata = $urandom;
    @(posedge i_sys_clk); @(negedge i_sys_clk);
    i_lsu_mem_rsp_valid = 1'b0;
    check(tag, {o_sys_valid, o_sys_ready, o_lsu_mem_req_valid}, 3'b010);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_sys_rst = 1'b1;
    i_sys_valid = 1'b0;
    i_sys_ready = 1'b0;
    i_idu_ctr_lsu_type = '0;
    i_exu_res = '0;
    i_idu_rs2_data = '0;
    i_idu_rd_id = '0;
    i_idu_rd_wr_en = 1'b0;
    i_lsu_mem_req_ready = 1'b0;
    i_lsu_mem_rsp_valid = 1'b0;
    i_lsu_mem_rdata = '0;
    repeat (2) @(negedge i_sys_clk);
    check_all_zero("reset_vals");
    i_sys_rst = 1'b0;
    #1;
    check("ready_before_edge", o_sys_ready, 0);
    @(negedge i_sys_clk);
    check("ready_after_rst", o_sys_ready, 1);

    // Directed cases
    run_txn(LSU_NONE, 32'h1234_5678, 32'h0, 5'd5, 1'b1, 32'h0, 0, 1, 0, 1'b0);
    run_txn(LSU_LB,  32'h0000_0103, 32'h0, 5'd6, 1'b1, 32'h80AA_BBCC, 0, 1, 0, 1'b0);
    check("lb_literal", o_lsu_res, 32'hFFFF_FF80);
    run_txn(LSU_LBU, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 32'h80AA_BBCC, 0, 1, 0, 1'b0);
    check("lbu_literal", o_lsu_res, 32'h0000_0080);
    run_txn(LSU_SH,  32'h0000_0102, 32'hDEAD_BEEF, 5'd8, 1'b0, 32'h0, 0, 1, 1, 1'b1);
    run_txn(LSU_LW,  32'h0000_0200, 32'h0, 5'd9, 1'b1, 32'hCAFE_F00D, 3, 2, 0, 1'b1);
    run_txn(LSU_LW,  32'h0000_0204, 32'h0, 5'd10, 1'b1, 32'h1111_2222, 0, TMO + 1, 2, 1'b0);
    stale_rsp_idle("late_rsp_ignored");
    run_txn(4'hB, 32'hA5A5_5A5A, 32'h0, 5'd11, 1'b1, 32'h0, 0, 1, 0, 1'b0);
    run_txn(LSU_LHU, 32'h0000_0302, 32'h0, 5'd12, 1'b1, 32'h8123_4567, 1, TMO, 0, 1'b0);
`ifdef LSU_MISALIGN_CHK_EN
    run_txn(LSU_LW, 32'h0000_0101, 32'h0, 5'd13, 1'b1, 32'h0, 0, 1, 0, 1'b0);
`endif

    // Reset while waiting for a response
    i_sys_valid = 1'b1;
    i_idu_ctr_lsu_type = LSU_LW;
    i_exu_res = 32'h0000_0400;
    i_idu_rd_wr_en = 1'b1;
    @(posedge i_sys_clk); @(negedge i_sys_clk);
    i_sys_valid = 1'b0;
    i_lsu_mem_req_ready = 1'b1;
    @(posedge i_sys_clk); @(negedge i_sys_clk);
    i_lsu_mem_req_ready = 1'b0;
    i_sys_rst = 1'b1;
    #1;
    check_all_zero("rst_in_wait");
    @(negedge i_sys_clk);
    i_sys_rst = 1'b0;
    @(negedge i_sys_clk);
    check("rst_wait_ready", o_sys_ready, 1);
    stale_rsp_idle("rst_wait_stale");

    // Reset coinciding with the request handshake
    i_sys_valid = 1'b1;
    i_idu_ctr_lsu_type = LSU_SW;
    i_exu_res = 32'h0000_0500;
    @(posedge i_sys_clk); @(negedge i_sys_clk);
    i_sys_valid = 1'b0;
    check("rst_hs_req", o_lsu_mem_req_valid, 1);
    i_lsu_mem_req_ready = 1'b1;
    i_sys_rst = 1'b1;
    @(posedge i_sys_clk); @(negedge i_sys_clk);
    check_all_zero("rst_hs_vals");
    i_sys_rst = 1'b0;
    i_lsu_mem_req_ready = 1'b0;
    @(negedge i_sys_clk);
    stale_rsp_idle("rst_hs_stale");

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      logic [3:0] t;
      t = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      run_txn(t, $urandom, $urandom, 5'($urandom), 1'($urandom), $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(1, TMO + 1)),
              int'($urandom_range(0, 2)), 1'($urandom));
      repeat ($urandom_range(0, 1)) @(negedge i_sys_clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
